// File: rtl/sid_pkg.sv
// Shared definitions for the SID register-write SPI master: register map,
// frame geometry, FSM state encoding and the frame packing helper.
package sid_pkg;

    // SID register addresses carried in the top three frame bits
    localparam logic [2:0] FREQ_LO  = 3'd0;
    localparam logic [2:0] FREQ_HI  = 3'd1;
    localparam logic [2:0] PW_LO    = 3'd2;
    localparam logic [2:0] PW_HI    = 3'd3;
    localparam logic [2:0] ATTACK   = 3'd4;
    localparam logic [2:0] SUSTAIN  = 3'd5;
    localparam logic [2:0] WAVEFORM = 3'd6;

    // Serial frame length and queued command width ({addr, data})
    localparam int SPI_FRAME_W = 16;
    localparam int CMD_W       = 11;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } sid_state_e;

    // Pack a queued {addr[2:0], data[7:0]} command into the 16-bit wire frame.
    // Address 7 is not reserved and passes through unchanged.
    function automatic logic [SPI_FRAME_W-1:0] sid_frame(input logic [CMD_W-1:0] cmd);
        return {cmd[10:8], 5'b00000, cmd[7:0]};
    endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// Write-request queue for the SID SPI master. Show-ahead read: the head
// entry is visible on pop_data_o whenever the queue is non-empty, so the
// sequencer can load a frame on the same edge it pops.
module sid_cmd_fifo
    import sid_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    // No bypass: a push while full is dropped even if a pop happens on the same edge
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, one write port; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sid_spi_master.sv
// SPI master that serialises queued SID register writes as 16-bit
// CPOL=0/CPHA=0 frames: SETUP (cs low, clk low), 16 clock periods, HOLD,
// then a cs-high GAP. Back-to-back frames start directly from GAP.
module sid_spi_master
    import sid_pkg::*;
#(
    parameter int CLK_DIV    = 4,   // SPI half-period in clk cycles, 2..255
    parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       spi_cs_n,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       busy
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT   = 5'(SPI_FRAME_W - 1);

    sid_state_e             state_q;
    sid_state_e             state_d;
    logic [7:0]             phase_q;
    logic [7:0]             phase_d;
    logic [4:0]             bit_cnt_q;
    logic [4:0]             bit_cnt_d;
    logic [SPI_FRAME_W-1:0] shift_q;
    logic [SPI_FRAME_W-1:0] shift_d;
    logic                   cs_n_q;
    logic                   cs_n_d;
    logic                   sclk_q;
    logic                   sclk_d;
    logic                   mosi_q;
    logic                   mosi_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CMD_W-1:0]       fifo_dout;
    logic [SPI_FRAME_W-1:0] next_frame;
    logic                   phase_end;
    logic                   start_frame;

    sid_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_valid),
        .push_data_i ({wr_addr, wr_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_dout),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign next_frame = sid_frame(fifo_dout);
    assign phase_end  = (phase_q == PHASE_LAST);

    assign wr_ready = !fifo_full;
    assign busy     = !fifo_empty || (state_q != IDLE);
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

    // Frame sequencer: phase counter paces every state, outputs are computed
    // here and registered below so the SPI pins never see a combinational path
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                start_frame = !fifo_empty;
            end

            SETUP: begin
                if (phase_end) begin
                    phase_d   = 8'd0;
                    sclk_d    = 1'b1;
                    bit_cnt_d = 5'd0;
                    state_d   = SHIFT;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            SHIFT: begin
                if (phase_end) begin
                    phase_d = 8'd0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit; after the last bit park mosi low
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[SPI_FRAME_W-2:0], 1'b0};
                        mosi_d  = (bit_cnt_q == LAST_BIT) ? 1'b0 : shift_q[SPI_FRAME_W-2];
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            HOLD: begin
                if (phase_end) begin
                    phase_d = 8'd0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            GAP: begin
                if (phase_end) begin
                    phase_d = 8'd0;
                    // The IDLE re-entry edge doubles as the next frame's start edge
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            fifo_pop  = 1'b1;
            shift_d   = next_frame;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            mosi_d    = next_frame[SPI_FRAME_W-1];
            phase_d   = 8'd0;
            bit_cnt_d = 5'd0;
            state_d   = SETUP;
        end
    end

    // State, counters, shift register and SPI pin registers; reset aborts any frame at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 8'd0;
            bit_cnt_q <= 5'd0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

endmodule

// File: tb/tb_sid_spi_master.sv
// Directed bench for sid_spi_master: one instance at CLK_DIV=4 and one at
// CLK_DIV=2, each watched by an SPI decoder that rebuilds frames and timing.
module tb_sid_spi_master;

    typedef struct {
        logic [15:0] frame;
        int          rises;
        int          low_len;
        int          gap;     // cycles from previous cs_n rise to this frame's cs_n fall
        int          period;  // cycles from previous cs_n fall to this frame's cs_n fall
    } frame_t;

    logic       clk;
    logic       rst;

    logic       a_valid, a_ready, a_cs_n, a_sclk, a_mosi, a_busy;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_cs_n, b_sclk, b_mosi, b_busy;
    logic [2:0] b_addr;
    logic [7:0] b_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // decoder state per instance
    logic        p_cs [2];
    logic        p_sclk [2];
    logic        p_mosi [2];
    logic [15:0] m_sh [2];
    int          m_bits [2];
    int          m_low [2];
    int          last_rise [2];
    int          last_fall [2];
    int          cur_gap [2];
    int          cur_period [2];
    int          n_falls [2];
    int          v_mosi_idle [2];
    int          v_sclk_edge [2];
    int          v_mosi_chg [2];
    frame_t      fq0 [$];
    frame_t      fq1 [$];
    logic [7:0]  slave_regs [8];

    sid_spi_master #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (a_valid),
        .wr_ready (a_ready),
        .wr_addr  (a_addr),
        .wr_data  (a_data),
        .spi_cs_n (a_cs_n),
        .spi_clk  (a_sclk),
        .spi_mosi (a_mosi),
        .busy     (a_busy)
    );

    sid_spi_master #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (b_valid),
        .wr_ready (b_ready),
        .wr_addr  (b_addr),
        .wr_data  (b_data),
        .spi_cs_n (b_cs_n),
        .spi_clk  (b_sclk),
        .spi_mosi (b_mosi),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_reset(input int id);
        p_cs[id]       = 1'b1;
        p_sclk[id]     = 1'b0;
        p_mosi[id]     = 1'b0;
        m_sh[id]       = 16'h0;
        m_bits[id]     = 0;
        m_low[id]      = 0;
        last_rise[id]  = -1;
        last_fall[id]  = -1;
        cur_gap[id]    = -1;
        cur_period[id] = -1;
    endtask

    task automatic mon_step(input int id, input logic cs, input logic sclk, input logic mosi);
        frame_t rec;
        if (cs && mosi) v_mosi_idle[id]++;
        if (p_cs[id] && !cs) begin
            n_falls[id]++;
            if (sclk) v_sclk_edge[id]++;
            cur_gap[id]    = (last_rise[id] >= 0) ? cyc - last_rise[id] : -1;
            cur_period[id] = (last_fall[id] >= 0) ? cyc - last_fall[id] : -1;
            last_fall[id]  = cyc;
            m_sh[id]       = 16'h0;
            m_bits[id]     = 0;
            m_low[id]      = 0;
        end
        if (!cs) m_low[id]++;
        if (!cs && !p_sclk[id] && sclk) begin
            m_sh[id] = {m_sh[id][14:0], mosi};
            m_bits[id]++;
            if (mosi !== p_mosi[id]) v_mosi_chg[id]++;
        end
        if (p_sclk[id] && sclk && (mosi !== p_mosi[id])) v_mosi_chg[id]++;
        if (!p_cs[id] && cs) begin
            if (sclk) v_sclk_edge[id]++;
            rec.frame   = m_sh[id];
            rec.rises   = m_bits[id];
            rec.low_len = m_low[id];
            rec.gap     = cur_gap[id];
            rec.period  = cur_period[id];
            last_rise[id] = cyc;
            if (id == 0) begin
                fq0.push_back(rec);
                slave_regs[rec.frame[15:13]] = rec.frame[7:0];
            end else begin
                fq1.push_back(rec);
            end
            $display("frame dut%0d data=0x%04h rises=%0d cs_low=%0d gap=%0d period=%0d",
                     id, rec.frame, rec.rises, rec.low_len, rec.gap, rec.period);
        end
        p_cs[id]   = cs;
        p_sclk[id] = sclk;
        p_mosi[id] = mosi;
    endtask

    // SPI decoders, sampled on the falling clk edge
    initial begin
        for (int i = 0; i < 2; i++) begin
            mon_reset(i);
            n_falls[i] = 0;
            v_mosi_idle[i] = 0;
            v_sclk_edge[i] = 0;
            v_mosi_chg[i]  = 0;
        end
        for (int r = 0; r < 8; r++) slave_regs[r] = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_reset(0);
                mon_reset(1);
            end else begin
                mon_step(0, a_cs_n, a_sclk, a_mosi);
                mon_step(1, b_cs_n, b_sclk, b_mosi);
            end
        end
    end

    task automatic pop_rec(input int id, output frame_t r);
        r.frame = 16'hDEAD; r.rises = -1; r.low_len = -1; r.gap = -1; r.period = -1;
        if (id == 0) begin
            if (fq0.size() > 0) r = fq0.pop_front();
        end else begin
            if (fq1.size() > 0) r = fq1.pop_front();
        end
    endtask

    // Present one request at a negedge and return at the negedge after it is accepted
    task automatic send(input int id, input logic [2:0] a, input logic [7:0] d, output int waits);
        int n;
        n = 0;
        if (id == 0) begin
            a_valid = 1'b1; a_addr = a; a_data = d;
            while (!a_ready && n < 3000) begin @(negedge clk); n++; end
        end else begin
            b_valid = 1'b1; b_addr = a; b_data = d;
            while (!b_ready && n < 3000) begin @(negedge clk); n++; end
        end
        if (n >= 3000) check_val("send_timeout", 32'd1, 32'd0);
        waits = n;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int id, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (((id == 0) ? a_busy : b_busy) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check_val({tag, "_timeout"}, 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        frame_t      r;
        int          w;
        int          wsum;
        int          n;
        int          f0;
        logic [15:0] exp5 [5];
        exp5[0] = 16'h0010; exp5[1] = 16'h2011; exp5[2] = 16'h4012;
        exp5[3] = 16'h6013; exp5[4] = 16'h8014;

        rst = 1'b1;
        a_valid = 1'b0; a_addr = 3'd0; a_data = 8'd0;
        b_valid = 1'b0; b_addr = 3'd0; b_data = 8'd0;
        repeat (3) @(negedge clk);

        // reset state
        check_val("rst_cs_n",  a_cs_n,  1'b1);
        check_val("rst_sclk",  a_sclk,  1'b0);
        check_val("rst_mosi",  a_mosi,  1'b0);
        check_val("rst_busy",  a_busy,  1'b0);
        check_val("rst_ready", a_ready, 1'b1);
        check_val("rst_ready_b", b_ready, 1'b1);
        check_val("rst_cs_n_b",  b_cs_n,  1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write: addr 6, data 0x41
        send(0, 3'd6, 8'h41, w);
        a_valid = 1'b0;
        check_val("single_busy", a_busy, 1'b1);
        wait_idle(0, "single");
        pop_rec(0, r);
        check_val("single_frame", r.frame, 16'hC041);
        check_val("single_rises", r.rises, 32'd16);
        check_val("single_cs_low", r.low_len, 32'd136);

        // frequency register via two back-to-back writes
        fq0.delete();
        send(0, 3'd0, 8'h34, w);
        send(0, 3'd1, 8'h12, w);
        a_valid = 1'b0;
        wait_idle(0, "freq");
        pop_rec(0, r);
        check_val("freq_lo_frame", r.frame, 16'h0034);
        pop_rec(0, r);
        check_val("freq_hi_frame", r.frame, 16'h2012);
        check_val("freq_b2b_period", r.period, 32'd140);
        check_val("freq_b2b_gap", r.gap, 32'd4);
        check_val("slave_freq", {slave_regs[1], slave_regs[0]}, 16'h1234);

        // five back-to-back requests into a depth-4 queue
        fq0.delete();
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            send(0, 3'(i), 8'(8'h10 + i), w);
            wsum += w;
        end
        check_val("b2b_no_wait", wsum, 32'd0);
        check_val("b2b_full_ready", a_ready, 1'b0);
        // request while full must be ignored
        a_addr = 3'd7; a_data = 8'hAA;
        repeat (3) @(negedge clk);
        a_valid = 1'b0;
        check_val("full_ignored_ready", a_ready, 1'b0);
        wait_idle(0, "b2b");
        check_val("b2b_count", fq0.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            pop_rec(0, r);
            check_val($sformatf("b2b_frame%0d", i), r.frame, exp5[i]);
        end
        check_val("b2b_ready_after", a_ready, 1'b1);

        // reset in the middle of a frame with two entries queued
        fq0.delete();
        f0 = n_falls[0];
        send(0, 3'd0, 8'h01, w);
        send(0, 3'd1, 8'h02, w);
        send(0, 3'd2, 8'h03, w);
        a_valid = 1'b0;
        n = 0;
        while (!(n_falls[0] > f0 && m_bits[0] >= 7) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check_val("abort_wait_timeout", 32'd1, 32'd0);
        check_val("abort_pre_cs_n", a_cs_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_val("abort_cs_n", a_cs_n, 1'b1);
        check_val("abort_sclk", a_sclk, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        f0 = n_falls[0];
        repeat (400) @(negedge clk);
        check_val("abort_no_falls", n_falls[0] - f0, 32'd0);
        check_val("abort_no_frames", fq0.size(), 32'd0);
        check_val("abort_busy", a_busy, 1'b0);
        check_val("abort_ready", a_ready, 1'b1);

        // CLK_DIV=2 instance: addr 7 passes unchanged, back-to-back spacing
        fq1.delete();
        send(1, 3'd7, 8'hFF, w);
        send(1, 3'd5, 8'h5A, w);
        b_valid = 1'b0;
        wait_idle(1, "div2");
        pop_rec(1, r);
        check_val("div2_frame0", r.frame, 16'hE0FF);
        check_val("div2_rises0", r.rises, 32'd16);
        check_val("div2_cs_low0", r.low_len, 32'd68);
        pop_rec(1, r);
        check_val("div2_frame1", r.frame, 16'hA05A);
        check_val("div2_gap", r.gap, 32'd2);
        check_val("div2_period", r.period, 32'd70);

        // protocol rules accumulated by the decoders over the whole run
        check_val("mosi_idle_a",  v_mosi_idle[0], 32'd0);
        check_val("sclk_at_cs_a", v_sclk_edge[0], 32'd0);
        check_val("mosi_stable_a", v_mosi_chg[0], 32'd0);
        check_val("mosi_idle_b",  v_mosi_idle[1], 32'd0);
        check_val("sclk_at_cs_b", v_sclk_edge[1], 32'd0);
        check_val("mosi_stable_b", v_mosi_chg[1], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
